// File: rtl/calsoc_pkg.sv
// Shared SoC definitions: timer register offsets, CTRL layout and a byte-lane merge helper.
package calsoc_pkg;

  localparam logic [4:0] TMR_CTRL_OFS   = 5'h00;
  localparam logic [4:0] TMR_PRESC_OFS  = 5'h04;
  localparam logic [4:0] TMR_COUNT_OFS  = 5'h08;
  localparam logic [4:0] TMR_CMP_OFS    = 5'h0C;
  localparam logic [4:0] TMR_STATUS_OFS = 5'h10;

  localparam int unsigned TMR_CTRL_EN_BIT       = 0;
  localparam int unsigned TMR_CTRL_IE_BIT       = 1;
  localparam int unsigned TMR_CTRL_PERIODIC_BIT = 2;

  typedef struct packed {
    logic periodic;
    logic ie;
    logic en;
  } tmr_ctrl_t;

  // Byte lanes with sel=0 keep the old value.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tmr_prescaler.sv
// Timer prescaler: emits a one-cycle tick every (presc + 1) enabled cycles.
module tmr_prescaler #(
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PRESC_WIDTH-1:0] presc,
  input  logic                   clr,
  output logic                   tick
);

  localparam logic [PRESC_WIDTH-1:0] CntOne = 1;

  logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == presc);

  always_comb begin
    cnt_d = cnt_q + CntOne;
    if (!en || clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone-B4 pipelined timer: 32-bit counter with prescaler, compare match and level IRQ.
module wb_timer
  import calsoc_pkg::*;
#(
  parameter int unsigned PRESC_WIDTH = 16,
  parameter logic [31:0] RESET_CMP   = 32'hFFFF_FFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o,
  output logic        irq_o
);

  tmr_ctrl_t              ctrl_q, ctrl_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [31:0]            count_q, count_d;
  logic [31:0]            cmp_q, cmp_d;
  logic                   match_q, match_d;
  logic                   irq_q;
  logic                   ack_q, err_q;
  logic [31:0]            dat_q;

  logic        req, mapped, wr, tick, presc_clr;
  logic [4:0]  ofs;
  logic [31:0] rdata, wdata;
  logic        unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign ofs        = {wb_adr_i[4:2], 2'b00};
  assign mapped     = (ofs <= TMR_STATUS_OFS);
  assign wr         = req & wb_we_i & mapped;
  assign presc_clr  = wr && (ofs == TMR_PRESC_OFS);
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  tmr_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_presc (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .en   (ctrl_q.en),
    .presc(presc_q),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Read mux reflects pre-edge register state.
  always_comb begin
    rdata = '0;
    case (ofs)
      TMR_CTRL_OFS: begin
        rdata[TMR_CTRL_EN_BIT]       = ctrl_q.en;
        rdata[TMR_CTRL_IE_BIT]       = ctrl_q.ie;
        rdata[TMR_CTRL_PERIODIC_BIT] = ctrl_q.periodic;
      end
      TMR_PRESC_OFS:  rdata[PRESC_WIDTH-1:0] = presc_q;
      TMR_COUNT_OFS:  rdata = count_q;
      TMR_CMP_OFS:    rdata = cmp_q;
      TMR_STATUS_OFS: rdata[0] = match_q;
      default:        rdata = '0;
    endcase
  end

  assign wdata = apply_sel(rdata, wb_dat_i, wb_sel_i);

  // Order matters: W1C loses to a new match, software writes beat tick updates.
  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;

    if (wr && (ofs == TMR_STATUS_OFS) && wb_sel_i[0] && wb_dat_i[0]) begin
      match_d = 1'b0;
    end

    if (tick) begin
      if (count_q == cmp_q) begin
        match_d = 1'b1;
        if (ctrl_q.periodic) begin
          count_d = '0;
        end else begin
          count_d   = count_q + 32'd1;
          ctrl_d.en = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr) begin
      case (ofs)
        TMR_CTRL_OFS: begin
          ctrl_d.en       = wdata[TMR_CTRL_EN_BIT];
          ctrl_d.ie       = wdata[TMR_CTRL_IE_BIT];
          ctrl_d.periodic = wdata[TMR_CTRL_PERIODIC_BIT];
        end
        TMR_PRESC_OFS: presc_d = wdata[PRESC_WIDTH-1:0];
        TMR_COUNT_OFS: count_d = wdata;
        TMR_CMP_OFS:   cmp_d   = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      count_q <= '0;
      cmp_q   <= RESET_CMP;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      irq_q   <= match_q & ctrl_q.ie;
      ack_q   <= req & mapped;
      err_q   <= req & ~mapped;
      dat_q   <= (req && !wb_we_i && mapped) ? rdata : '0;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = 1'b0;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: register vectors, timer corner sequences, randomized runs.
module tb_wb_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        ack, err, stall, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_timer dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_i),
    .wb_dat_o  (dat_o),
    .wb_we_i   (we),
    .wb_sel_i  (sel),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .wb_stall_o(stall),
    .irq_o     (irq)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One single-cycle request; returns the response seen in the following cycle.
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output logic k,
                     output logic e);
    adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    r = dat_o; k = ack; e = err;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic k, e;
    bus(a, 1'b1, d, 4'hF, r, k, e);
    chk($sformatf("wr %h ack", a), 32'(k), 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] r;
    logic k, e;
    bus(a, 1'b0, '0, 4'hF, r, k, e);
    chk({nm, " ack"}, 32'(k), 32'd1);
    chk(nm, r, exp);
  endtask

  task automatic rd_get(input logic [31:0] a, output logic [31:0] r);
    logic k, e;
    bus(a, 1'b0, '0, 4'hF, r, k, e);
  endtask

  // Reference: tick count t since enable, distance d = CMP - COUNT0 (non-negative).
  function automatic logic [31:0] m_count(longint c0, longint d, bit per, longint t);
    if (t <= d) return 32'(c0 + t);
    if (!per) return 32'(c0 + d + 1);
    return 32'((t - d - 1) % (c0 + d + 1));
  endfunction

  function automatic bit m_match(longint d, longint t);
    return t >= d + 1;
  endfunction

  task automatic setup(input logic [31:0] p, input logic [31:0] cmpv, input logic [31:0] c0);
    wr(32'h00, 32'h0);
    wr(32'h10, 32'h1);
    wr(32'h04, p);
    wr(32'h0C, cmpv);
    wr(32'h08, c0);
  endtask

  initial begin
    logic [31:0] r;
    logic k, e;
    int n;

    vt.push_back('{32'h00, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0});
    vt.push_back('{32'h04, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0});
    vt.push_back('{32'h08, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0});
    vt.push_back('{32'h0C, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'hFFFF_FFFF});
    vt.push_back('{32'h10, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0});
    vt.push_back('{32'h18, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0});
    vt.push_back('{32'h08, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0, 32'h0});
    vt.push_back('{32'h08, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h00BB_00DD});
    vt.push_back('{32'h14, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'h0});
    vt.push_back('{32'hFFFF_FF0A, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h00BB_00DD});
    vt.push_back('{32'h04, 1'b1, 32'hFFFF_1234, 4'hF, 1'b1, 1'b0, 32'h0});
    vt.push_back('{32'h04, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0000_1234});
    vt.push_back('{32'h00, 1'b1, 32'hFFFF_FFFA, 4'hF, 1'b1, 1'b0, 32'h0});
    vt.push_back('{32'h00, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h2});
    vt.push_back('{32'h0C, 1'b1, 32'h1200_0000, 4'b1000, 1'b1, 1'b0, 32'h0});
    vt.push_back('{32'h0C, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h12FF_FFFF});
    vt.push_back('{32'h00, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0});
    vt.push_back('{32'h1C, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset dat", dat_o, 32'h0);
    chk("reset irq", 32'(irq), 32'd0);
    rst = 1'b0;
    chk("stall", 32'(stall), 32'd0);

    foreach (vt[i]) begin
      bus(vt[i].adr, vt[i].we, vt[i].dat, vt[i].sel, r, k, e);
      chk($sformatf("vec%0d ack", i), 32'(k), 32'(vt[i].ack));
      chk($sformatf("vec%0d err", i), 32'(e), 32'(vt[i].err));
      chk($sformatf("vec%0d dat", i), r, vt[i].rdat);
    end

    // Request without cyc is ignored.
    adr = 32'h08; we = 1'b1; dat_i = 32'h5555_5555; sel = 4'hF; stb = 1'b1; cyc = 1'b0;
    @(posedge clk); #1;
    chk("nocyc ack", 32'(ack), 32'd0);
    stb = 1'b0; we = 1'b0;
    rd(32'h08, 32'h00BB_00DD, "nocyc count");

    // Periodic: PRESC=3, CMP=5.
    setup(32'd3, 32'd5, 32'd0);
    wr(32'h00, 32'h7);
    n = 0;
    while (!irq && n < 100) begin @(posedge clk); #1; n++; end
    chk("periodic irq delay", 32'(n), 32'd25);
    rd(32'h08, 32'h0, "periodic count after match");
    wr(32'h10, 32'h1);
    chk("irq held after w1c", 32'(irq), 32'd1);
    @(posedge clk); #1;
    chk("irq drop after w1c", 32'(irq), 32'd0);
    n = 0;
    while (!irq && n < 100) begin @(posedge clk); #1; n++; end
    chk("periodic repeat delay", 32'(n), 32'd21);

    // One-shot: PRESC=0, CMP=2.
    setup(32'd0, 32'd2, 32'd0);
    wr(32'h00, 32'h3);
    repeat (5) @(posedge clk);
    #1;
    rd(32'h10, 32'h1, "oneshot status");
    rd(32'h00, 32'h2, "oneshot ctrl");
    rd(32'h08, 32'h3, "oneshot count");
    chk("oneshot irq", 32'(irq), 32'd1);

    // Silent wrap through zero.
    setup(32'd0, 32'd10, 32'hFFFF_FFFF);
    wr(32'h00, 32'h1);
    rd(32'h08, 32'hFFFF_FFFF, "wrap count0");
    rd(32'h08, 32'h0, "wrap count1");
    rd(32'h10, 32'h0, "wrap status");
    rd(32'h08, 32'h2, "wrap count3");

    // COUNT write on the edge of a matching one-shot tick.
    setup(32'd0, 32'd5, 32'd5);
    wr(32'h00, 32'h1);
    wr(32'h08, 32'h0);
    rd(32'h08, 32'h0, "collide count");
    rd(32'h10, 32'h1, "collide status");
    rd(32'h00, 32'h0, "collide ctrl");

    // W1C on the edge of a new match: set wins.
    setup(32'd0, 32'd3, 32'd3);
    wr(32'h00, 32'h5);
    wr(32'h10, 32'h1);
    rd(32'h10, 32'h1, "w1c vs set");

    // Four-read burst with cyc/stb held.
    setup(32'd7, 32'h55, 32'h1234);
    begin
      logic [31:0] ba[4];
      logic [31:0] be[4];
      ba = '{32'h00, 32'h04, 32'h08, 32'h0C};
      be = '{32'h0, 32'h7, 32'h1234, 32'h55};
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
      for (int i = 0; i < 4; i++) begin
        adr = ba[i];
        @(posedge clk); #1;
        chk($sformatf("burst%0d ack", i), 32'(ack), 32'd1);
        chk($sformatf("burst%0d dat", i), dat_o, be[i]);
      end
      cyc = 1'b0; stb = 1'b0;
    end

    // Randomized runs against the arithmetic model.
    for (int it = 0; it < 24; it++) begin
      int p, c0, d, w, t;
      bit per, ie;
      logic [31:0] got;
      p   = $urandom_range(0, 3);
      c0  = $urandom_range(0, 1000);
      d   = $urandom_range(0, 12);
      per = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      w   = $urandom_range(0, 50);
      setup(32'(p), 32'(c0 + d), 32'(c0));
      wr(32'h00, {29'b0, per, ie, 1'b1});
      repeat (w) @(posedge clk);
      #1;
      t = w / (p + 1);
      rd_get(32'h08, got);
      chk($sformatf("rand%0d count", it), got, m_count(c0, d, per, t));
      chk($sformatf("rand%0d irq", it), 32'(irq), 32'(m_match(d, t) & ie));
      t = (w + 1) / (p + 1);
      rd_get(32'h10, got);
      chk($sformatf("rand%0d status", it), got, 32'(m_match(d, t)));
      t = (w + 2) / (p + 1);
      rd_get(32'h00, got);
      chk($sformatf("rand%0d ctrl", it), got,
          {29'b0, per, ie, per | ~m_match(d, t)});
    end

    // Reset while an ack is showing drops it and restores reset values.
    wr(32'h00, 32'h0);
    adr = 32'h08; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("pre-reset ack", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset drops ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rd(32'h08, 32'h0, "post-reset count");
    rd(32'h0C, 32'hFFFF_FFFF, "post-reset cmp");
    rd(32'h04, 32'h0, "post-reset presc");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
